// File: rtl/seg_pkg.sv
// Shared constants and code classification for the 7-segment scan controller.
package seg_pkg;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  // Codes above the dash have no glyph and are shown dark.
  function automatic logic is_blank_code(input logic [3:0] code);
    return code > CODE_DASH;
  endfunction

endpackage

// File: rtl/bin2seg.sv
// Decodes a 4-bit digit code into active-low {a,b,c,d,e,f,g,dp} segment drives.
module bin2seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
    seg[7:1] = SEG_OFF[7:1];
    case (code)
      4'd0:      seg[7:1] = 7'b0000001;
      4'd1:      seg[7:1] = 7'b1001111;
      4'd2:      seg[7:1] = 7'b0010010;
      4'd3:      seg[7:1] = 7'b0000110;
      4'd4:      seg[7:1] = 7'b1001100;
      4'd5:      seg[7:1] = 7'b0100100;
      4'd6:      seg[7:1] = 7'b0100000;
      4'd7:      seg[7:1] = 7'b0001101;
      4'd8:      seg[7:1] = 7'b0000000;
      4'd9:      seg[7:1] = 7'b0000100;
      CODE_DASH: seg[7:1] = 7'b1111110;
      default:   seg[7:1] = SEG_OFF[7:1];
    endcase
    seg[0] = ~dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display,
// with a double-buffered frame, leading-zero suppression and anti-ghosting guard time.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int TICK_DIV  = 50000,
  parameter int GUARD_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*N_DIGITS-1:0] wr_codes,
  input  logic [N_DIGITS-1:0]   wr_dp,
  input  logic                  wr_lz,
  output logic                  pending,
  output logic                  frame_done,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(N_DIGITS);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

  typedef logic [N_DIGITS-1:0][3:0] codes_t;

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;

  codes_t              shadow_codes;
  logic [N_DIGITS-1:0] shadow_dp;
  logic                shadow_lz;
  codes_t              active_codes;
  logic [N_DIGITS-1:0] active_dp;
  logic                active_lz;

  logic                slot_end;
  logic                frame_wrap;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic [N_DIGITS-1:0] lz_mask;
  logic [7:0]          dec_seg;
  logic [7:0]          seg_next;
  logic [N_DIGITS-1:0] an_next;

  assign slot_end   = (presc == PRESC_MAX);
  assign frame_wrap = slot_end && (idx == IDX_MAX);
  assign cur_code   = active_codes[idx];
  assign cur_dp     = active_dp[idx];

  // Zeros are blanked from the top digit down until the first non-zero code;
  // digit 0 is excluded so a value of zero still shows one glyph.
  always_comb begin
    logic run;
    lz_mask = '0;
    run     = active_lz;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (run && (active_codes[i] == 4'd0)) begin
        lz_mask[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  bin2seg u_bin2seg (
    .code (cur_code),
    .dp   (cur_dp),
    .seg  (dec_seg)
  );

  always_comb begin
    seg_next = dec_seg;
    if (is_blank_code(cur_code) || lz_mask[idx]) begin
      seg_next = {SEG_OFF[7:1], dec_seg[0]};
    end
    an_next = '1;
    if (presc >= GUARD_END) begin
      an_next[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: every register, buffers included, is reset so a pending frame cannot survive reset.
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      shadow_codes <= {N_DIGITS{CODE_BLANK}};
      shadow_dp    <= '0;
      shadow_lz    <= 1'b0;
      active_codes <= {N_DIGITS{CODE_BLANK}};
      active_dp    <= '0;
      active_lz    <= 1'b0;
      pending      <= 1'b0;
      frame_done   <= 1'b0;
      seg          <= SEG_OFF;
      an           <= '1;
    end else begin
      // NOTE: non-blocking assignments let the commit read the old shadow on the same edge a write lands.
      presc      <= slot_end ? '0 : presc + PW'(1);
      frame_done <= frame_wrap;
      if (slot_end) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end

      if (frame_wrap && pending) begin
        active_codes <= shadow_codes;
        active_dp    <= shadow_dp;
        active_lz    <= shadow_lz;
      end

      if (wr_en) begin
        shadow_codes <= codes_t'(wr_codes);
        shadow_dp    <= wr_dp;
        shadow_lz    <= wr_lz;
        pending      <= 1'b1;
      end else if (frame_wrap) begin
        pending      <= 1'b0;
      end

      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with N_DIGITS=4, TICK_DIV=8, GUARD_CYC=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_codes;
  logic [3:0]  wr_dp;
  logic        wr_lz;
  logic        pending;
  logic        frame_done;
  logic [7:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_ctrl #(
    .N_DIGITS  (4),
    .TICK_DIV  (8),
    .GUARD_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_codes   (wr_codes),
    .wr_dp      (wr_dp),
    .wr_lz      (wr_lz),
    .pending    (pending),
    .frame_done (frame_done),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an === target) found = 1'b1;
    end
    check({tag, "_an_reached"}, 32'(found), 32'd1);
  endtask

  task automatic wait_fd(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) found = 1'b1;
    end
    check({tag, "_frame_done"}, 32'(found), 32'd1);
  endtask

  // Expected segments packed as {digit3, digit2, digit1, digit0}.
  task automatic show_frame(input logic [31:0] exp_segs, input string tag);
    for (int d = 0; d < 4; d++) begin
      wait_an(~(4'b0001 << d), $sformatf("%s_d%0d", tag, d));
      check($sformatf("%s_seg_d%0d", tag, d), 32'(seg), 32'(exp_segs[8*d +: 8]));
    end
  endtask

  task automatic write_frame(input logic [15:0] codes, input logic [3:0] dp, input logic lz);
    wr_codes = codes;
    wr_dp    = dp;
    wr_lz    = lz;
    wr_en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_an;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_codes = 16'h0;
    wr_dp    = 4'h0;
    wr_lz    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seg",        32'(seg),        32'hFF);
    check("rst_an",         32'(an),         32'hF);
    check("rst_pending",    32'(pending),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Blank scan: guard cycles, one-hot-low anodes, frame_done every 32 cycles.
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      exp_an = 4'hF;
      if (((k - 1) % 8) >= 2) exp_an[((k - 1) / 8) % 4] = 1'b0;
      check($sformatf("scan_an_k%0d", k),  32'(an),         32'(exp_an));
      check($sformatf("scan_seg_k%0d", k), 32'(seg),        32'hFF);
      check($sformatf("scan_fd_k%0d", k),  32'(frame_done), 32'((k % 32) == 0));
    end

    // Plain digits.
    write_frame(16'h4321, 4'h0, 1'b0);
    check("wr_pending_set", 32'(pending), 32'd1);
    wait_fd("f4321");
    check("f4321_pending_clr", 32'(pending), 32'd0);
    show_frame({8'h99, 8'h0D, 8'h25, 8'h9F}, "f4321");

    // Leading-zero suppression.
    write_frame(16'h0075, 4'h0, 1'b1);
    wait_fd("f0075");
    show_frame({8'hFF, 8'hFF, 8'h1B, 8'h49}, "f0075");
    write_frame(16'h0000, 4'h0, 1'b1);
    wait_fd("f0000");
    show_frame({8'hFF, 8'hFF, 8'hFF, 8'h03}, "f0000");

    // Decimal points and dash.
    write_frame(16'hA888, 4'b0010, 1'b0);
    wait_fd("fA888");
    show_frame({8'hFD, 8'h01, 8'h00, 8'h01}, "fA888");
    write_frame(16'hA8A8, 4'b0010, 1'b0);
    wait_fd("fA8A8");
    show_frame({8'hFD, 8'h01, 8'hFC, 8'h01}, "fA8A8");

    // Blank codes are dark without lz, dp still independent.
    write_frame(16'hFB0C, 4'b0100, 1'b0);
    wait_fd("fFB0C");
    show_frame({8'hFF, 8'hFE, 8'h03, 8'hFF}, "fFB0C");

    // Write A mid-frame, then B exactly on the wrap edge.
    wait_fd("pre_ab");
    write_frame(16'h6789, 4'h0, 1'b0);
    repeat (30) @(negedge clk);
    write_frame(16'h2345, 4'h0, 1'b0);
    check("ab_wrap_hit",      32'(frame_done), 32'd1);
    check("ab_pending_kept",  32'(pending),    32'd1);
    show_frame({8'h41, 8'h1B, 8'h01, 8'h09}, "fA");
    wait_fd("fB");
    check("fB_pending_clr", 32'(pending), 32'd0);
    show_frame({8'h25, 8'h0D, 8'h99, 8'h49}, "fB");

    // Reset mid-slot with a pending frame.
    write_frame(16'h1111, 4'hF, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_pending", 32'(pending), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_seg",        32'(seg),        32'hFF);
    check("mid_rst_an",         32'(an),         32'hF);
    check("mid_rst_pending",    32'(pending),    32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_guard_an", 32'(an), 32'hF);
    end
    @(negedge clk);
    check("post_rst_d0_an",  32'(an),  32'hE);
    check("post_rst_d0_seg", 32'(seg), 32'hFF);
    wait_fd("post_rst");
    check("post_rst_pending", 32'(pending), 32'd0);
    show_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF}, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
